// File: rtl/count_chk_pkg.sv
// Shared types and default widths for the count sequence checker.
package count_chk_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    localparam int COUNT_W_DEF = 4;
    localparam int TALLY_W_DEF = 8;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter used for the wrap and error tallies; clr beats inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/count_sequence_checker.sv
// Consumer-side checker for a free-running up-counter: tracks count+1 sequencing,
// separates restarts at 0 from sequence errors, and keeps saturating tallies.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ACQUIRE | waiting for count_in == 0 before checking begins
//   TRACK   | every enabled sample must equal expected (or restart at 0)
module count_sequence_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH = COUNT_W_DEF,
    parameter int CNT_W = TALLY_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             restart_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] bad_value,
    output logic [WIDTH-1:0] expected
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    state_t state;

    logic tracking;
    logic is_match;
    logic is_zero;
    logic err_hit;
    logic wrap_hit;

    assign tracking = enable && (state == TRACK);
    assign is_match = (count_in == expected);
    assign is_zero  = (count_in == '0);
    // A stalled or skipped value is an error; a jump back to 0 is a restart.
    assign err_hit  = tracking && !is_match && !is_zero;
    assign wrap_hit = tracking && is_match && (count_in == MAX);

    assign locked = (state == TRACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACQUIRE;
            expected      <= '0;
            bad_value     <= '0;
            err_pulse     <= 1'b0;
            restart_pulse <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            err_pulse     <= 1'b0;
            restart_pulse <= 1'b0;
            if (enable) begin
                case (state)
                    ACQUIRE: begin
                        if (is_zero) begin
                            state    <= TRACK;
                            expected <= ONE;
                        end
                    end
                    TRACK: begin
                        if (is_match) begin
                            expected <= count_in + ONE;
                        end else if (is_zero) begin
                            restart_pulse <= 1'b1;
                            expected      <= ONE;
                        end else begin
                            err_pulse <= 1'b1;
                            bad_value <= count_in;
                            state     <= ACQUIRE;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
            if (clear) begin
                err_sticky <= 1'b0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (wrap_hit),
        .q     (wrap_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_hit),
        .q     (err_count)
    );

endmodule
